// File: rtl/regfile_wb_pkg.sv
// rtl/regfile_wb_pkg.sv - shared types and round-robin pick for the write-back arbiter
package regfile_wb_pkg;
  localparam int AW_DEF  = 5;
  localparam int DW_DEF  = 32;
  localparam int MAX_SRC = 16;
  localparam int SRC_IW  = 4;

  typedef struct packed {
    logic [AW_DEF-1:0] rd;
    logic [DW_DEF-1:0] data;
  } wb_entry_t;

  // First requester at or after ptr, wrapping at nsrc; returns 0 when nothing requests.
  function automatic logic [SRC_IW-1:0] rr_pick(input logic [MAX_SRC-1:0] req,
                                               input logic [SRC_IW-1:0]  ptr,
                                               input int unsigned        nsrc);
    logic [SRC_IW-1:0] pick;
    logic              found;
    int unsigned       idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_SRC; k++) begin
      idx = (int'(ptr) + k) % nsrc;
      if (!found && (k < nsrc) && req[idx[SRC_IW-1:0]]) begin
        pick  = idx[SRC_IW-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - producer, write-port and hazard-query bundle (WB_STALL_CNT_EN adds stall_cnt)
interface regfile_wb_arbiter_if import regfile_wb_pkg::*; #(
  parameter int NSRC = 2,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
);
  logic [NSRC-1:0]    src_valid;
  logic [NSRC-1:0]    src_ready;
  logic [NSRC*AW-1:0] src_rd;
  logic [NSRC*DW-1:0] src_data;
  logic               RegWr;
  logic [AW-1:0]      RD;
  logic [DW-1:0]      WData;
  logic               busy;
  logic [AW-1:0]      q_addr1;
  logic [AW-1:0]      q_addr2;
  logic               q_pend1;
  logic               q_pend2;
`ifdef WB_STALL_CNT_EN
  logic [15:0]        stall_cnt;

  modport master (output src_valid, src_rd, src_data, q_addr1, q_addr2,
                  input  src_ready, RegWr, RD, WData, busy, q_pend1, q_pend2, stall_cnt);
  modport slave  (input  src_valid, src_rd, src_data, q_addr1, q_addr2,
                  output src_ready, RegWr, RD, WData, busy, q_pend1, q_pend2, stall_cnt);
`else
  modport master (output src_valid, src_rd, src_data, q_addr1, q_addr2,
                  input  src_ready, RegWr, RD, WData, busy, q_pend1, q_pend2);
  modport slave  (input  src_valid, src_rd, src_data, q_addr1, q_addr2,
                  output src_ready, RegWr, RD, WData, busy, q_pend1, q_pend2);
`endif
endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - per-producer write-back FIFO exposing every slot for hazard matching
module wb_fifo import regfile_wb_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  wb_entry_t         entry_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output wb_entry_t         head_o,
  output logic [AW_DEF-1:0] rd_o [DEPTH],
  output logic [DEPTH-1:0]  vld_o
);
  localparam int PW = $clog2(DEPTH);

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, off;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    off   = '0;
    vld_o = '0;
    for (int j = 0; j < DEPTH; j++) begin
      off      = PW'(j) - rptr_q;
      vld_o[j] = ({1'b0, off} < cnt_q);
      rd_o[j]  = mem_q[j].rd;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= entry_i;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin share of the register-file write port among NSRC producers
// Optional WB_STALL_CNT_EN: saturating count of cycles where a producer is held off.
module regfile_wb_arbiter import regfile_wb_pkg::*; #(
  parameter int NSRC  = 2,
  parameter int DEPTH = 2,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                  Clk,
  input  logic                  Reset,
  regfile_wb_arbiter_if.slave   bus
);
  wb_entry_t         head     [NSRC];
  wb_entry_t         push_ent [NSRC];
  logic [AW_DEF-1:0] ents_rd  [NSRC][DEPTH];
  logic [DEPTH-1:0]  vld      [NSRC];
  logic [NSRC-1:0]   full, empty, push, pop;
  logic [MAX_SRC-1:0] req;
  logic [SRC_IW-1:0] rr_q, rr_d, grant;
  logic              any_req;
  wb_entry_t         win;
  logic              regwr_q, regwr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              pend1, pend2;

  assign bus.src_ready = Reset ? ~full : '0;

  // Writes to x0 complete the handshake but never occupy a slot.
  always_comb begin
    push = '0;
    for (int i = 0; i < NSRC; i++) begin
      push_ent[i] = {bus.src_rd[i*AW +: AW], bus.src_data[i*DW +: DW]};
      push[i]     = bus.src_valid[i] && bus.src_ready[i] && (bus.src_rd[i*AW +: AW] != '0);
    end
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (Clk),
      .rst_ni  (Reset),
      .push_i  (push[i]),
      .entry_i (push_ent[i]),
      .pop_i   (pop[i]),
      .full_o  (full[i]),
      .empty_o (empty[i]),
      .head_o  (head[i]),
      .rd_o    (ents_rd[i]),
      .vld_o   (vld[i])
    );
  end

  always_comb begin
    req            = '0;
    req[NSRC-1:0]  = ~empty;
    any_req        = |req;
    grant          = rr_pick(req, rr_q, NSRC);
    win            = head[0];
    pop            = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (grant == SRC_IW'(i)) begin
        win    = head[i];
        pop[i] = any_req;
      end
    end
    rr_d    = rr_q;
    regwr_d = any_req;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    if (any_req) begin
      rr_d    = (grant == SRC_IW'(NSRC-1)) ? '0 : grant + 1'b1;
      rd_d    = win.rd;
      wdata_d = win.data;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rr_q    <= '0;
      regwr_q <= 1'b0;
      rd_q    <= '0;
      wdata_q <= '0;
    end else begin
      rr_q    <= rr_d;
      regwr_q <= regwr_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
    end
  end

  // The in-flight output register counts as pending until its write lands.
  always_comb begin
    pend1 = regwr_q && (rd_q == bus.q_addr1);
    pend2 = regwr_q && (rd_q == bus.q_addr2);
    for (int i = 0; i < NSRC; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (vld[i][j] && (ents_rd[i][j] == bus.q_addr1)) pend1 = 1'b1;
        if (vld[i][j] && (ents_rd[i][j] == bus.q_addr2)) pend2 = 1'b1;
      end
    end
    if (bus.q_addr1 == '0) pend1 = 1'b0;
    if (bus.q_addr2 == '0) pend2 = 1'b0;
  end

  assign bus.q_pend1 = pend1;
  assign bus.q_pend2 = pend2;
  assign bus.RegWr   = regwr_q;
  assign bus.RD      = rd_q;
  assign bus.WData   = wdata_q;
  assign bus.busy    = (|(~empty)) || regwr_q;

`ifdef WB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        stall;

  always_comb begin
    stall       = |(bus.src_valid & ~bus.src_ready);
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized self-checking bench with a queue-based write-back model
module tb_regfile_wb_arbiter;
  localparam int NSRC = 2, DEPTH = 2, AW = 5, DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.NSRC(NSRC), .AW(AW), .DW(DW)) bus ();
  regfile_wb_arbiter #(.NSRC(NSRC), .DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .Clk(clk), .Reset(rst_n), .bus(bus));

  int n_chk = 0, n_fail = 0;

  logic [AW+DW-1:0] mq [NSRC][$];
  int               m_rr;
  logic             m_regwr;
  logic [AW-1:0]    m_rd;
  logic [DW-1:0]    m_wdata;
  int               m_stall;

  task automatic model_reset();
    for (int i = 0; i < NSRC; i++) mq[i].delete();
    m_rr = 0; m_regwr = 1'b0; m_rd = '0; m_wdata = '0; m_stall = 0;
  endtask

  function automatic logic m_ready(int i);
    return mq[i].size() < DEPTH;
  endfunction

  function automatic logic m_busy();
    logic b;
    b = m_regwr;
    for (int i = 0; i < NSRC; i++) if (mq[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  function automatic logic m_pend(logic [AW-1:0] a);
    logic p;
    if (a == '0) return 1'b0;
    p = m_regwr && (m_rd == a);
    for (int i = 0; i < NSRC; i++)
      foreach (mq[i][k]) if (mq[i][k][AW+DW-1:DW] == a) p = 1'b1;
    return p;
  endfunction

  task automatic drive(int i, logic v, logic [AW-1:0] rd, logic [DW-1:0] d);
    bus.src_valid[i]       = v;
    bus.src_rd[i*AW +: AW] = rd;
    bus.src_data[i*DW +: DW] = d;
  endtask

  task automatic idle();
    bus.src_valid = '0; bus.src_rd = '0; bus.src_data = '0;
  endtask

  // One rising edge: grant from the pre-edge queues, then enqueue accepted writes.
  task automatic step();
    logic [NSRC-1:0]  acc;
    logic             stalled;
    int               g, idx;
    logic [AW+DW-1:0] e;
    @(posedge clk);
    stalled = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      acc[i] = bus.src_valid[i] && m_ready(i);
      if (bus.src_valid[i] && !acc[i]) stalled = 1'b1;
    end
    g = -1;
    for (int k = 0; k < NSRC; k++) begin
      idx = (m_rr + k) % NSRC;
      if (g < 0 && mq[idx].size() != 0) g = idx;
    end
    if (g >= 0) begin
      e = mq[g].pop_front();
      m_regwr = 1'b1; m_rd = e[AW+DW-1:DW]; m_wdata = e[DW-1:0];
      m_rr = (g + 1) % NSRC;
    end else m_regwr = 1'b0;
    for (int i = 0; i < NSRC; i++)
      if (acc[i] && bus.src_rd[i*AW +: AW] != '0)
        mq[i].push_back({bus.src_rd[i*AW +: AW], bus.src_data[i*DW +: DW]});
    if (stalled && m_stall < 65535) m_stall++;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; idle();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    n_chk++; if (bus.RegWr !== 1'b0) begin n_fail++; $display("FAIL reset_regwr: got %b want 0", bus.RegWr); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_chk++; if (bus.src_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", bus.src_ready); end
    n_chk++; if (bus.RD !== 5'd0 || bus.WData !== 32'd0) begin n_fail++; $display("FAIL reset_rd_wdata: got %h/%h want 0/0", bus.RD, bus.WData); end
    @(negedge clk); rst_n = 1'b1; model_reset(); #1;
    n_chk++; if (bus.src_ready !== 2'b11) begin n_fail++; $display("FAIL release_ready: got %b want 11", bus.src_ready); end
    drive(0, 1'b1, 5'd3, $urandom); drive(1, 1'b1, 5'd20, $urandom); step();
    drive(0, 1'b1, 5'd4, $urandom); drive(1, 1'b1, 5'd21, $urandom); step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_chk++; if (bus.RegWr !== 1'b0) begin n_fail++; $display("FAIL midburst_regwr: got %b want 0", bus.RegWr); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midburst_busy: got %b want 0", bus.busy); end
    n_chk++; if (bus.src_ready !== 2'b00) begin n_fail++; $display("FAIL midburst_ready: got %b want 00", bus.src_ready); end
    idle();
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_chk++; if (bus.RegWr !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL stale_write c%0d: got regwr=%b busy=%b want 0 0", c, bus.RegWr, bus.busy); end
    end
  endtask

  task automatic test_single();
    do_reset();
    drive(0, 1'b1, 5'd5, 32'hDEADBEEF); step(); idle();
    n_chk++; if (bus.RegWr !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_c1: got regwr=%b busy=%b want 0 1", bus.RegWr, bus.busy); end
    step();
    n_chk++; if (bus.RegWr !== 1'b1 || bus.RD !== 5'd5 || bus.WData !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_c2: got %b %0d %h want 1 5 deadbeef", bus.RegWr, bus.RD, bus.WData); end
    step();
    n_chk++; if (bus.RegWr !== 1'b0 || bus.RD !== 5'd5 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_c3: got regwr=%b rd=%0d busy=%b want 0 5 0", bus.RegWr, bus.RD, bus.busy); end
  endtask

  task automatic test_contention();
    logic [AW-1:0] r0, r1;
    logic [DW-1:0] d0, d1;
    logic          a0, a1, saw_full;
    int            nwr;
    do_reset();
    r0 = 5'd1; r1 = 5'd17; d0 = $urandom; d1 = $urandom; saw_full = 1'b0; nwr = 0;
    for (int c = 0; c < 16; c++) begin
      drive(0, 1'b1, r0, d0); drive(1, 1'b1, r1, d1);
      bus.q_addr1 = 5'($urandom_range(0, 31)); bus.q_addr2 = r0;
      #1;
      n_chk++; if (bus.src_ready !== {m_ready(1), m_ready(0)}) begin n_fail++; $display("FAIL cont_ready c%0d: got %b want %b", c, bus.src_ready, {m_ready(1), m_ready(0)}); end
      if (bus.src_ready != 2'b11) saw_full = 1'b1;
      a0 = m_ready(0); a1 = m_ready(1);
      step();
      if (a0) begin r0 = r0 + 1'b1; d0 = $urandom; end
      if (a1) begin r1 = r1 + 1'b1; d1 = $urandom; end
      n_chk++; if (bus.RegWr !== m_regwr || bus.RD !== m_rd || bus.WData !== m_wdata) begin n_fail++; $display("FAIL cont_out c%0d: got %b %0d %h want %b %0d %h", c, bus.RegWr, bus.RD, bus.WData, m_regwr, m_rd, m_wdata); end
      n_chk++; if (bus.q_pend1 !== m_pend(bus.q_addr1) || bus.q_pend2 !== m_pend(bus.q_addr2)) begin n_fail++; $display("FAIL cont_pend c%0d: got %b%b want %b%b", c, bus.q_pend1, bus.q_pend2, m_pend(bus.q_addr1), m_pend(bus.q_addr2)); end
      if (bus.RegWr === 1'b1) begin
        nwr++;
        if (nwr == 1) begin n_chk++; if (bus.RD !== 5'd1) begin n_fail++; $display("FAIL cont_first: got %0d want 1", bus.RD); end end
        if (nwr == 2) begin n_chk++; if (bus.RD !== 5'd17) begin n_fail++; $display("FAIL cont_second: got %0d want 17", bus.RD); end end
      end
    end
    n_chk++; if (saw_full !== 1'b1) begin n_fail++; $display("FAIL cont_fill: got %b want 1", saw_full); end
    idle();
    for (int c = 0; c < 12 && m_busy(); c++) begin
      step();
      n_chk++; if (bus.RegWr !== m_regwr || bus.RD !== m_rd || bus.WData !== m_wdata || bus.busy !== m_busy()) begin n_fail++; $display("FAIL drain c%0d: got %b %0d %h %b want %b %0d %h %b", c, bus.RegWr, bus.RD, bus.WData, bus.busy, m_regwr, m_rd, m_wdata, m_busy()); end
    end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL drain_done: got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_x0();
    do_reset();
    drive(1, 1'b1, 5'd0, 32'h1234); #1;
    n_chk++; if (bus.src_ready[1] !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %b want 1", bus.src_ready[1]); end
    step(); idle();
    for (int c = 0; c < 3; c++) begin
      n_chk++; if (bus.RegWr !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL x0_c%0d: got regwr=%b busy=%b want 0 0", c, bus.RegWr, bus.busy); end
      step();
    end
  endtask

  task automatic test_hazard();
    do_reset();
    bus.q_addr1 = 5'd9; bus.q_addr2 = 5'd0; #1;
    n_chk++; if (bus.q_pend1 !== 1'b0) begin n_fail++; $display("FAIL haz_before: got %b want 0", bus.q_pend1); end
    drive(0, 1'b1, 5'd9, $urandom); step(); idle();
    n_chk++; if (bus.q_pend1 !== 1'b1 || bus.q_pend2 !== 1'b0 || bus.RegWr !== 1'b0) begin n_fail++; $display("FAIL haz_queued: got p1=%b p2=%b regwr=%b want 1 0 0", bus.q_pend1, bus.q_pend2, bus.RegWr); end
    step();
    n_chk++; if (bus.q_pend1 !== 1'b1 || bus.q_pend2 !== 1'b0 || bus.RegWr !== 1'b1 || bus.RD !== 5'd9) begin n_fail++; $display("FAIL haz_write: got p1=%b p2=%b regwr=%b rd=%0d want 1 0 1 9", bus.q_pend1, bus.q_pend2, bus.RegWr, bus.RD); end
    step();
    n_chk++; if (bus.q_pend1 !== 1'b0 || bus.q_pend2 !== 1'b0) begin n_fail++; $display("FAIL haz_after: got p1=%b p2=%b want 0 0", bus.q_pend1, bus.q_pend2); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < NSRC; i++)
        drive(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31)), $urandom);
      bus.q_addr1 = 5'($urandom_range(0, 31)); bus.q_addr2 = 5'($urandom_range(0, 7));
      #1;
      n_chk++; if (bus.src_ready !== {m_ready(1), m_ready(0)}) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", c, bus.src_ready, {m_ready(1), m_ready(0)}); end
      step();
      n_chk++; if (bus.RegWr !== m_regwr || bus.RD !== m_rd || bus.WData !== m_wdata || bus.busy !== m_busy()) begin n_fail++; $display("FAIL rnd_out c%0d: got %b %0d %h %b want %b %0d %h %b", c, bus.RegWr, bus.RD, bus.WData, bus.busy, m_regwr, m_rd, m_wdata, m_busy()); end
      n_chk++; if (bus.q_pend1 !== m_pend(bus.q_addr1) || bus.q_pend2 !== m_pend(bus.q_addr2)) begin n_fail++; $display("FAIL rnd_pend c%0d: got %b%b want %b%b", c, bus.q_pend1, bus.q_pend2, m_pend(bus.q_addr1), m_pend(bus.q_addr2)); end
    end
    idle();
  endtask

`ifdef WB_STALL_CNT_EN
  task automatic test_stall_cnt();
    do_reset();
    n_chk++; if (bus.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL stall_reset: got %0d want 0", bus.stall_cnt); end
    drive(0, 1'b1, 5'd7, $urandom); drive(1, 1'b1, 5'd8, $urandom);
    for (int c = 0; c < 60 && m_stall < 10; c++) step();
    n_chk++; if (bus.stall_cnt !== 16'd10) begin n_fail++; $display("FAIL stall_10: got %0d want 10", bus.stall_cnt); end
    force dut.stall_cnt_q = 16'hFFFE;
    #1 release dut.stall_cnt_q;
    for (int c = 0; c < 5; c++) step();
    n_chk++; if (bus.stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL stall_sat: got %h want ffff", bus.stall_cnt); end
    idle();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.q_addr1 = '0; bus.q_addr2 = '0;
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_x0();
    test_hazard();
    test_random();
`ifdef WB_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
